alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus a radix-2 shift-add multiplier.
// Operands are registered on the accepting edge; results and done appear one edge later (N+1 for MUL).
module alu_mc #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   f,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic [N-1:0] y_hi,
  output logic         z,
  output logic         ovf
);
  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  typedef struct packed {
    logic [N-1:0] y;
    logic [N-1:0] y_hi;
    logic         z;
    logic         ovf;
  } res_t;

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [3:0]    f_q, f_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;
  res_t          res_q, res_d;

  logic          accept;
  logic [N-1:0]  add_r, sub_r, alu_y;
  logic          alu_ovf;
  logic [N:0]    msum;

  always_comb begin
    add_r   = a_q + b_q;
    sub_r   = a_q - b_q;
    alu_y   = '0;
    alu_ovf = 1'b0;
    case (f_q)
      4'd0: alu_y = a_q & b_q;
      4'd1: alu_y = a_q | b_q;
      4'd2: begin
        alu_y   = sub_r;
        alu_ovf = (a_q[N-1] != b_q[N-1]) && (sub_r[N-1] != a_q[N-1]);
      end
      4'd3: alu_y = {{(N-1){1'b0}}, a_q == b_q};
      4'd4: alu_y = {{(N-1){1'b0}}, $signed(a_q) > $signed(b_q)};
      4'd5: begin
        alu_y   = add_r;
        alu_ovf = (a_q[N-1] == b_q[N-1]) && (add_r[N-1] != a_q[N-1]);
      end
      4'd6: alu_y = a_q << b_q[SW-1:0];
      4'd7: alu_y = a_q >> b_q[SW-1:0];
      default: alu_y = '0;
    endcase
  end

  // b_q doubles as the multiplier shift register; the product low half fills in from the top.
  assign msum   = {1'b0, acc_q} + {1'b0, (b_q[0] ? a_q : {N{1'b0}})};
  // A pending single-cycle op blocks acceptance so a held start is not taken twice.
  assign accept = start && (state_q == S_IDLE) && !pend_q;

  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    f_d     = f_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = (state_q != S_IDLE);
    done_d  = 1'b0;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          res_d.y    = alu_y;
          res_d.y_hi = '0;
          res_d.z    = (alu_y == '0);
          res_d.ovf  = alu_ovf;
          done_d     = 1'b1;
        end
        if (accept) begin
          a_d = a;
          b_d = b;
          f_d = f;
          if (f == 4'd8) begin
            acc_d   = '0;
            cnt_d   = CW'(N);
            state_d = S_MUL;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = msum[N:1];
        b_d   = {msum[0], b_q[N-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        res_d.y    = b_q;
        res_d.y_hi = acc_q;
        res_d.z    = (b_q == '0);
        res_d.ovf  = 1'b0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      f_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '{y: '0, y_hi: '0, z: 1'b1, ovf: 1'b0};
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      f_q     <= f_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = res_q.y;
  assign y_hi = res_q.y_hi;
  assign z    = res_q.z;
  assign ovf  = res_q.ovf;
endmodule
